fetch_sequencer: RTL and testbench

Instruction-fetch sequencer for the single-cycle RISC-V core. It sequences the program counter by producing the PC update enable and next-PC select. It handshakes with an instruction memory that may insert wait states, and with the execute stage. It also provides start/halt control, a fetch-timeout error and a retired-instruction count.

---
 rtl/fetch_sequencer.sv | 90 +++++++++
 tb/tb_fetch_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC-update sequencing, IMEM handshake, start/halt control, fetch timeout and retire count
module fetch_sequencer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        halt_i,
    input  logic        imem_rdy_i,
    input  logic        exec_done_i,
    input  logic        branch_req_i,
    output logic        imem_req_o,
    output logic        instr_valid_o,
    output logic        pc_en_o,
    output logic        pc_src_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [1:0]  state_o,
    output logic [31:0] retired_o
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_FETCH = 2'b01;
    localparam logic [1:0] S_EXEC  = 2'b10;
    localparam logic [1:0] S_ERROR = 2'b11;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halt_q, halt_d;
    logic [31:0]      retired_q;
    logic             stop;

    assign stop = halt_q | halt_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                halt_d = 1'b0;
                state_d = start_i ? S_FETCH : S_IDLE;
            end
            S_FETCH: begin
                halt_d = stop;
                if (imem_rdy_i)
                    state_d = S_EXEC;
                else if (cnt_q == LIMIT)
                    state_d = S_ERROR;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_EXEC: begin
                halt_d = stop;
                if (exec_done_i) begin
                    cnt_d   = '0;
                    halt_d  = 1'b0;
                    state_d = stop ? S_IDLE : S_FETCH;
                end
            end
            default: state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            halt_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            halt_q    <= halt_d;
            retired_q <= pc_en_o ? retired_q + 32'd1 : retired_q;
        end
    end

    // Only the PC strobe and its select look at live inputs; everything else is state decode
    assign pc_en_o       = (state_q == S_EXEC) & exec_done_i;
    assign pc_src_o      = pc_en_o & branch_req_i;
    assign imem_req_o    = state_q == S_FETCH;
    assign instr_valid_o = state_q == S_EXEC;
    assign busy_o        = state_q != S_IDLE;
    assign err_o         = state_q == S_ERROR;
    assign state_o       = state_q;
    assign retired_o     = retired_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench against an instruction-level reference model
module tb_fetch_sequencer;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, halt = 1'b0, rdy = 1'b0, done = 1'b0, br = 1'b0;
    logic imem_req, instr_valid, pc_en, pc_src, busy, err;
    logic [1:0]  state;
    logic [31:0] retired;

    fetch_sequencer #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .halt_i(halt),
        .imem_rdy_i(rdy), .exec_done_i(done), .branch_req_i(br),
        .imem_req_o(imem_req), .instr_valid_o(instr_valid), .pc_en_o(pc_en),
        .pc_src_o(pc_src), .busy_o(busy), .err_o(err), .state_o(state),
        .retired_o(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req, valid, en, src, busy, err;
        logic [1:0]  st;
        logic [31:0] ret;
    } obs_t;

    obs_t exp_q[$];
    int vectors = 0, miscompares = 0;

    // Reference model: sequencer running? instruction held? fetch gave up? halt requested?
    bit running = 0, holding = 0, dead = 0, halt_req = 0;
    int waited = 0;
    int unsigned ret_cnt = 0;

    task automatic step(input bit r, input bit s, input bit h, input bit m, input bit d, input bit b);
        obs_t e;
        @(negedge clk);
        rst = r; start = s; halt = h; rdy = m; done = d; br = b;
        e = '0;
        if (!r) begin
            e.req   = running && !holding;
            e.valid = holding;
            e.en    = holding && d;
            e.src   = holding && d && b;
            e.busy  = running || dead;
            e.err   = dead;
            e.st    = dead ? 2'd3 : holding ? 2'd2 : running ? 2'd1 : 2'd0;
            e.ret   = ret_cnt;
        end
        exp_q.push_back(e);
        if (r) begin
            running = 0; holding = 0; dead = 0; halt_req = 0; waited = 0; ret_cnt = 0;
        end else if (dead) begin
        end else if (!running) begin
            if (s) begin running = 1; waited = 0; end
        end else if (!holding) begin
            halt_req |= h;
            if (m) holding = 1;
            else if (waited + 1 == TO) begin dead = 1; running = 0; end
            else waited++;
        end else begin
            halt_req |= h;
            if (d) begin
                ret_cnt++;
                holding = 0;
                waited = 0;
                if (halt_req) begin running = 0; halt_req = 0; end
            end
        end
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic rand_seg(input int n, input int p_rdy, input int p_done, input int p_halt, input int p_rst);
        for (int i = 0; i < n; i++)
            step(rnd(p_rst), rnd(30), rnd(p_halt), rnd(p_rdy), rnd(p_done), rnd(50));
    endtask

    initial begin : monitor
        obs_t a, e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {imem_req, instr_valid, pc_en, pc_src, busy, err, state, retired};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got req=%b val=%b en=%b src=%b busy=%b err=%b st=%0d ret=%0d, want req=%b val=%b en=%b src=%b busy=%b err=%b st=%0d ret=%0d",
                             $time, a.req, a.valid, a.en, a.src, a.busy, a.err, a.st, a.ret,
                             e.req, e.valid, e.en, e.src, e.busy, e.err, e.st, e.ret);
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 0);
        // slow memory, two-cycle execute, second instruction branches
        for (int n = 0; n < 3; n++) begin
            for (int w = 0; w < 3; w++) step(0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 1, n == 1);
        end
        // timeout, START ignored in ERROR, then reset recovers
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < TO + 6; i++) step(0, i[0], i[1], 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // RDY arrives exactly on the limit cycle
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < TO + 3; i++) step(0, 0, 0, holding == 0 && waited == TO - 1, 1, 0);
        // halt during a 2-wait fetch, then a fresh START
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // async reset while EXEC_DONE is high
        step(1, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        rand_seg(600, 70, 60, 10, 1);
        rand_seg(400, 8, 60, 5, 3);
        rand_seg(600, 50, 40, 25, 1);
        step(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
